calendar_counter: RTL and testbench

- Downstream neighbour of the 24 h time-of-day counter.
- Consumes the counter's 5-bit binary hour output and detects midnight as a 23→0 transition.
- Advances a day/month/year date with month lengths and leap years. Supports paused manual adjustment via push buttons.
- Drives binary date outputs and BCD digit pairs for the 7-segment display mux.

---
 rtl/cal_pkg.sv | 64 ++++++
 rtl/cal_btn_edge.sv | 24 ++
 rtl/calendar_counter.sv | 146 ++++++++++++++
 tb/tb_calendar_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared calendar constants and helpers: month numbers, month lengths,
// leap-year rule and binary-to-BCD split for the date display digits.
package cal_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [4:0] DAYS_30  = 5'd30;
  localparam logic [4:0] DAYS_31  = 5'd31;
  localparam logic [4:0] FEB_LEAP = 5'd29;
  localparam logic [4:0] FEB_NORM = 5'd28;

  localparam logic [6:0] YEAR_MAX = 7'd99;

  // Bit positions inside the packed button vector.
  localparam int BTN_DAY_INC = 0;
  localparam int BTN_DAY_DEC = 1;
  localparam int BTN_MON_INC = 2;
  localparam int BTN_MON_DEC = 3;
  localparam int BTN_YR_INC  = 4;
  localparam int BTN_YR_DEC  = 5;
  localparam int BTN_COUNT   = 6;

  typedef enum logic [1:0] {
    ADJ_NONE,
    ADJ_DAY,
    ADJ_MONTH,
    ADJ_YEAR
  } adj_field_e;

  // Only 2000..2099 is representable, so year % 4 is the exact rule.
  function automatic logic is_leap(input logic [6:0] year);
    return (year[1:0] == 2'b00);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] dim;
    case (month)
      APR, JUN, SEP, NOV: dim = DAYS_30;
      FEB:                dim = leap ? FEB_LEAP : FEB_NORM;
      default:            dim = DAYS_31;
    endcase
    return dim;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = value / 7'd10;
    ones = value % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/cal_btn_edge.sv
// Rising-edge detector for a vector of button levels. Reset loads the
// current levels so a button held through reset does not register a press.
module cal_btn_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= level;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/calendar_counter.sv
// Day/month/year calendar advanced on the 23->0 hour rollover, with
// paused push-button adjustment and BCD digit outputs for the display mux.
module calendar_counter
  import cal_pkg::*;
#(
  parameter int INIT_DAY   = 1,
  parameter int INIT_MONTH = 1,
  parameter int INIT_YEAR  = 0
) (
  input  logic       clk_1hz,
  input  logic       date_reset,
  input  logic [4:0] hour_in,
  input  logic       date_pause,
  input  logic       day_inc,
  input  logic       day_dec,
  input  logic       mon_inc,
  input  logic       mon_dec,
  input  logic       yr_inc,
  input  logic       yr_dec,
  output logic [4:0] day_out,
  output logic [3:0] month_out,
  output logic [6:0] year_out,
  output logic       leap_year,
  output logic       midnight_pulse,
  output logic [3:0] day_1s,
  output logic [3:0] day_10s,
  output logic [3:0] mon_1s,
  output logic [3:0] mon_10s,
  output logic [3:0] yr_1s,
  output logic [3:0] yr_10s
);

  logic [4:0]           hour_prev;
  logic [BTN_COUNT-1:0] btn_level;
  logic [BTN_COUNT-1:0] rise;
  logic                 midnight;
  logic [4:0]           dim_cur;
  adj_field_e           adj_sel;
  logic [4:0]           day_n;
  logic [3:0]           month_n;
  logic [6:0]           year_n;
  logic [4:0]           dim_next;
  logic                 advance;

  assign btn_level = {yr_dec, yr_inc, mon_dec, mon_inc, day_dec, day_inc};

  cal_btn_edge #(
    .WIDTH(BTN_COUNT)
  ) u_btn_edge (
    .clk  (clk_1hz),
    .rst  (date_reset),
    .level(btn_level),
    .rise (rise)
  );

  assign leap_year = is_leap(year_out);
  assign dim_cur   = days_in_month(month_out, leap_year);
  assign midnight  = (hour_prev == 5'd23) && (hour_in == 5'd0);

  // A field with any edge claims the cycle, even if its inc and dec cancel.
  always_comb begin
    adj_sel = ADJ_NONE;
    if (date_pause) begin
      if (rise[BTN_YR_INC] || rise[BTN_YR_DEC]) begin
        adj_sel = ADJ_YEAR;
      end else if (rise[BTN_MON_INC] || rise[BTN_MON_DEC]) begin
        adj_sel = ADJ_MONTH;
      end else if (rise[BTN_DAY_INC] || rise[BTN_DAY_DEC]) begin
        adj_sel = ADJ_DAY;
      end
    end
  end

  always_comb begin
    day_n    = day_out;
    month_n  = month_out;
    year_n   = year_out;
    advance  = 1'b0;
    dim_next = DAYS_31;
    case (adj_sel)
      ADJ_YEAR: begin
        if (rise[BTN_YR_INC] && !rise[BTN_YR_DEC]) begin
          year_n = (year_out == YEAR_MAX) ? 7'd0 : year_out + 7'd1;
        end else if (rise[BTN_YR_DEC] && !rise[BTN_YR_INC]) begin
          year_n = (year_out == 7'd0) ? YEAR_MAX : year_out - 7'd1;
        end
      end
      ADJ_MONTH: begin
        if (rise[BTN_MON_INC] && !rise[BTN_MON_DEC]) begin
          month_n = (month_out == DEC) ? JAN : month_out + 4'd1;
        end else if (rise[BTN_MON_DEC] && !rise[BTN_MON_INC]) begin
          month_n = (month_out == JAN) ? DEC : month_out - 4'd1;
        end
      end
      ADJ_DAY: begin
        if (rise[BTN_DAY_INC] && !rise[BTN_DAY_DEC]) begin
          day_n = (day_out >= dim_cur) ? 5'd1 : day_out + 5'd1;
        end else if (rise[BTN_DAY_DEC] && !rise[BTN_DAY_INC]) begin
          day_n = (day_out <= 5'd1) ? dim_cur : day_out - 5'd1;
        end
      end
      default: begin
        if (!date_pause && midnight) begin
          advance = 1'b1;
          if (day_out < dim_cur) begin
            day_n = day_out + 5'd1;
          end else begin
            day_n = 5'd1;
            if (month_out == DEC) begin
              month_n = JAN;
              year_n  = (year_out == YEAR_MAX) ? 7'd0 : year_out + 7'd1;
            end else begin
              month_n = month_out + 4'd1;
            end
          end
        end
      end
    endcase
    // Month/year moves can leave the day past the end of the new month.
    dim_next = days_in_month(month_n, is_leap(year_n));
    if (day_n > dim_next) begin
      day_n = dim_next;
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (date_reset) begin
      day_out        <= 5'(INIT_DAY);
      month_out      <= 4'(INIT_MONTH);
      year_out       <= 7'(INIT_YEAR);
      midnight_pulse <= 1'b0;
      hour_prev      <= hour_in;
    end else begin
      day_out        <= day_n;
      month_out      <= month_n;
      year_out       <= year_n;
      midnight_pulse <= advance;
      hour_prev      <= hour_in;
    end
  end

  assign {day_10s, day_1s} = to_bcd({2'b00, day_out});
  assign {mon_10s, mon_1s} = to_bcd({3'b000, month_out});
  assign {yr_10s, yr_1s}   = to_bcd(year_out);

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: stimulus drives a date-arithmetic
// reference model and queues expectations; a monitor compares every cycle.
module tb_calendar_counter;

  localparam int INIT_D = 1;
  localparam int INIT_M = 1;
  localparam int INIT_Y = 0;

  logic       clk_1hz = 1'b0;
  logic       date_reset;
  logic [4:0] hour_in;
  logic       date_pause;
  logic       day_inc, day_dec, mon_inc, mon_dec, yr_inc, yr_dec;
  logic [4:0] day_out;
  logic [3:0] month_out;
  logic [6:0] year_out;
  logic       leap_year;
  logic       midnight_pulse;
  logic [3:0] day_1s, day_10s, mon_1s, mon_10s, yr_1s, yr_10s;

  always #5 clk_1hz = ~clk_1hz;

  calendar_counter #(
    .INIT_DAY  (INIT_D),
    .INIT_MONTH(INIT_M),
    .INIT_YEAR (INIT_Y)
  ) dut (
    .clk_1hz       (clk_1hz),
    .date_reset    (date_reset),
    .hour_in       (hour_in),
    .date_pause    (date_pause),
    .day_inc       (day_inc),
    .day_dec       (day_dec),
    .mon_inc       (mon_inc),
    .mon_dec       (mon_dec),
    .yr_inc        (yr_inc),
    .yr_dec        (yr_dec),
    .day_out       (day_out),
    .month_out     (month_out),
    .year_out      (year_out),
    .leap_year     (leap_year),
    .midnight_pulse(midnight_pulse),
    .day_1s        (day_1s),
    .day_10s       (day_10s),
    .mon_1s        (mon_1s),
    .mon_10s       (mon_10s),
    .yr_1s         (yr_1s),
    .yr_10s        (yr_10s)
  );

  typedef struct {
    int d;
    int m;
    int y;
    bit p;
  } exp_t;

  exp_t       sb[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         md, mm, my;
  int         m_prev_hour;
  bit [5:0]   m_prev_btn;
  int         cur_hour = 12;

  function automatic int dimOf(int m, int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Button vector order: {yr_dec, yr_inc, mon_dec, mon_inc, day_dec, day_inc}.
  task automatic applyStimulus(input bit rst, input int hour, input bit pause, input bit [5:0] btns);
    exp_t     e;
    bit [5:0] rise;
    int       dim;
    date_reset = rst;
    hour_in    = 5'(hour);
    date_pause = pause;
    {yr_dec, yr_inc, mon_dec, mon_inc, day_dec, day_inc} = btns;
    e.p = 1'b0;
    if (rst) begin
      md = INIT_D;
      mm = INIT_M;
      my = INIT_Y;
    end else begin
      rise = btns & ~m_prev_btn;
      if (m_prev_hour == 23 && hour == 0 && !pause) begin
        e.p = 1'b1;
        md = md + 1;
        if (md > dimOf(mm, my)) begin
          md = 1;
          mm = mm + 1;
          if (mm > 12) begin
            mm = 1;
            my = (my + 1) % 100;
          end
        end
      end else if (pause) begin
        if (rise[4] || rise[5]) begin
          if (rise[4] && !rise[5]) my = (my + 1) % 100;
          else if (rise[5] && !rise[4]) my = (my + 99) % 100;
        end else if (rise[2] || rise[3]) begin
          if (rise[2] && !rise[3]) mm = mm % 12 + 1;
          else if (rise[3] && !rise[2]) mm = (mm + 10) % 12 + 1;
        end else if (rise[0] || rise[1]) begin
          dim = dimOf(mm, my);
          if (rise[0] && !rise[1]) md = md % dim + 1;
          else if (rise[1] && !rise[0]) md = (md + dim - 2) % dim + 1;
        end
        if (md > dimOf(mm, my)) md = dimOf(mm, my);
      end
    end
    m_prev_hour = hour;
    m_prev_btn  = btns;
    cur_hour    = hour;
    e.d = md;
    e.m = mm;
    e.y = my;
    sb.push_back(e);
    @(negedge clk_1hz);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [23:0] bcd_exp;
    logic [23:0] bcd_act;
    tests_run++;
    if (day_out !== 5'(e.d) || month_out !== 4'(e.m) || year_out !== 7'(e.y)) begin
      tests_failed++;
      $display("[TB] FAIL date: got %0d/%0d/%0d, expected %0d/%0d/%0d at %0t",
               day_out, month_out, year_out, e.d, e.m, e.y, $time);
    end
    tests_run++;
    if (midnight_pulse !== e.p) begin
      tests_failed++;
      $display("[TB] FAIL midnight_pulse: got %b, expected %b at %0t", midnight_pulse, e.p, $time);
    end
    tests_run++;
    if (leap_year !== (e.y % 4 == 0)) begin
      tests_failed++;
      $display("[TB] FAIL leap_year: got %b, expected %b at %0t", leap_year, (e.y % 4 == 0), $time);
    end
    bcd_exp = {4'(e.d / 10), 4'(e.d % 10), 4'(e.m / 10), 4'(e.m % 10), 4'(e.y / 10), 4'(e.y % 10)};
    bcd_act = {day_10s, day_1s, mon_10s, mon_1s, yr_10s, yr_1s};
    tests_run++;
    if (bcd_act !== bcd_exp) begin
      tests_failed++;
      $display("[TB] FAIL bcd: got %h, expected %h at %0t", bcd_act, bcd_exp, $time);
    end
  endtask

  task automatic pressBtn(input int b);
    applyStimulus(1'b0, 12, 1'b1, 6'(1 << b));
    applyStimulus(1'b0, 12, 1'b1, 6'd0);
  endtask

  task automatic doMidnight(input bit pause);
    applyStimulus(1'b0, 23, pause, 6'd0);
    applyStimulus(1'b0, 0, pause, 6'd0);
    applyStimulus(1'b0, 1, pause, 6'd0);
  endtask

  task automatic setDate(input int td, input int tm, input int ty);
    while (my != ty) pressBtn(((ty - my + 100) % 100 <= 50) ? 4 : 5);
    while (mm != tm) pressBtn(((tm - mm + 12) % 12 <= 6) ? 2 : 3);
    while (md != td) pressBtn(((td - md + 31) % 31 <= 15) ? 0 : 1);
  endtask

  initial begin
    forever begin
      @(posedge clk_1hz);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    int r;
    int h;
    bit [5:0] b;

    applyStimulus(1'b1, 22, 1'b0, 6'd0);
    applyStimulus(1'b1, 22, 1'b0, 6'd0);
    applyStimulus(1'b0, 22, 1'b0, 6'd0);
    doMidnight(1'b0);

    setDate(31, 12, 99);
    doMidnight(1'b0);

    setDate(28, 2, 1);
    doMidnight(1'b0);
    setDate(28, 2, 4);
    doMidnight(1'b0);
    doMidnight(1'b0);

    setDate(29, 2, 4);
    pressBtn(4);
    setDate(31, 3, 5);
    pressBtn(3);

    setDate(10, 6, 10);
    repeat (5) applyStimulus(1'b0, 12, 1'b1, 6'b000001);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);
    applyStimulus(1'b0, 12, 1'b1, 6'b000011);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);
    applyStimulus(1'b0, 12, 1'b1, 6'b010001);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);
    applyStimulus(1'b0, 12, 1'b1, 6'b001100);
    applyStimulus(1'b0, 12, 1'b1, 6'b000001);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);

    doMidnight(1'b1);
    applyStimulus(1'b0, 12, 1'b0, 6'b000100);
    applyStimulus(1'b0, 12, 1'b0, 6'd0);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);

    setDate(15, 7, 23);
    applyStimulus(1'b0, 12, 1'b1, 6'b000001);
    applyStimulus(1'b0, 12, 1'b1, 6'b000001);
    applyStimulus(1'b1, 12, 1'b1, 6'b000001);
    repeat (3) applyStimulus(1'b0, 12, 1'b1, 6'b000001);
    applyStimulus(1'b0, 12, 1'b1, 6'd0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 7);
      if (r < 3) h = (cur_hour == 23) ? 0 : 23;
      else h = $urandom_range(0, 31);
      b = 6'($urandom) & 6'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, h, $urandom_range(0, 1) == 1, b);
    end

    repeat (3) @(negedge clk_1hz);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
